lcd_cmd_sequencer: RTL and testbench
====================================

# lcd_cmd_sequencer

Command/character sequencer that sits directly upstream of the LCD enable-pulse timing stage. After power-up it drives the fixed HD44780 8-bit initialization sequence onto the LCD bus, then accepts characters and commands from the temperature-display logic over a valid/ready handshake. For each byte it presents `LCD_RS`/`LCD_DATA`, triggers the enable stage, and holds the bus until that stage reports completion.

## Interface
- `P_PWRUP_CYC`, default 750000: power-on wait in `CLK` cycles (15 ms at 50 MHz). Legal range 1 to 2^23-1.
- `CLK` input 1: system clock; all state changes on the rising edge.
- `flag_rst` input 1: reset, asynchronous, active-high.
- `char_valid` input 1: upstream has a byte to write.
- `char_rs` input 1: register select for the offered byte (0 = command, 1 = data).
- `char_data` input 8: offered byte.
- `char_ready` output 1: block accepts a byte this cycle.
- `wr_done` input 1: completion level from the enable stage. Low while a write is in progress, high when done or idle.
- `wr_go` output 1: write request to the enable stage (level, held until acknowledged).
- `LCD_RS` output 1: register select to the LCD.
- `LCD_RW` output 1: always 0 (write only).
- `LCD_DATA` output 8: LCD data bus.
- `init_done` output 1: initialization complete; stays high until reset.

## Operation
- **Reset values.** `char_ready`=0, `wr_go`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_DATA`=8'h00, `init_done`=0. State = PWRUP, power-up counter = 0, init index = 0.
- **Init ROM.** Six entries, in order, all with RS=0: 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06.
- **PWRUP.** The counter increments every cycle and saturates at `P_PWRUP_CYC`. Exit when the counter equals `P_PWRUP_CYC` and `wr_done`=1. On exit, load ROM[0] onto `LCD_DATA` with `LCD_RS`=0, set `wr_go`=1, and go to ISSUE.
- **ISSUE.** Hold `wr_go`=1 while `wr_done`=1. On the first cycle `wr_done`=0 is sampled, set `wr_go`=0 and go to WAIT_HI.
- **WAIT_HI.** Wait for `wr_done`=1. Then:
  - During init with index < 5: increment the index, load the next ROM byte, set `wr_go`=1, and go to ISSUE.
  - During init with index = 5: set `init_done`=1 and `char_ready`=1, and go to IDLE.
  - For a user write: set `char_ready`=1 and go to IDLE.
- **IDLE.** `char_ready`=1. When `char_valid`=1 (a handshake), latch `char_rs`→`LCD_RS` and `char_data`→`LCD_DATA`, set `char_ready`=0 and `wr_go`=1, and go to ISSUE.
- **Bus stability.** `LCD_RS` and `LCD_DATA` change only on the load edges above. They are stable from the cycle `wr_go` rises until the next load.
- **Upstream input outside IDLE.** `char_valid` is ignored outside IDLE, including during PWRUP and init. No byte is dropped; upstream simply holds it.
- **No timeout.** If `wr_done` never falls, the block stays in ISSUE with `wr_go`=1 indefinitely.
- **Reset mid-operation.** Asserting `flag_rst` in any state returns all outputs to their reset values immediately. The full PWRUP and init sequence reruns after release.

## Timing
- **Accept to request.** Handshake at edge N; `wr_go`=1 and the new `LCD_DATA`/`LCD_RS` are visible after edge N. `char_ready`=0 after edge N.
- **Request release.** `wr_go` falls on the first edge at which `wr_done`=0 is sampled in ISSUE.
- **Completion to ready.** `wr_done` sampled high in WAIT_HI at edge M gives `char_ready`=1 after edge M. The next handshake is possible at edge M+1.
- **Throughput.** Minimum one write per (enable-stage duration + 3) cycles.
- **Power-up.** ROM[0] is issued no earlier than `P_PWRUP_CYC` cycles after reset release.
- **Counter width.** 23 bits, saturating, no wrap-around.

## Test plan
Bench model of the enable stage: `wr_done` drops 1 cycle after `wr_go` rises, rises 20 cycles later, and starts at 1. Set `P_PWRUP_CYC`=10.

- **Power-up and init.** Release reset → `wr_go` first rises after ≥10 cycles. `LCD_DATA` sequence is 38,38,38,0C,01,06 with `LCD_RS`=0 throughout. `init_done` and `char_ready` rise together after the 6th `wr_done` rise.
- **Single data write.** `char_valid`=1, `char_rs`=1, `char_data`=8'h41 in IDLE → next cycle `LCD_RS`=1, `LCD_DATA`=8'h41, `wr_go`=1, `char_ready`=0. Bus holds until `char_ready` returns 1.
- **Input during init.** `char_valid`=1 with 8'h55 from reset onward → not accepted until after `init_done`. Then exactly one write of 8'h55 occurs.
- **Delayed enable stage after power-up.** Hold `wr_done`=0 for 50 cycles after reset → ROM[0] is not issued before `wr_done`=1, even after the counter expires.
- **Stuck acknowledge.** Model keeps `wr_done`=1 after `wr_go` → `wr_go` stays 1, state unchanged, `char_ready` stays 0.
- **Reset mid-write.** Assert `flag_rst` during WAIT_HI of a user write → all outputs reset asynchronously. After release, the full init sequence repeats and `init_done`=0 until it completes.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Drives the HD44780 8-bit power-up/initialization sequence onto the LCD bus,
// then forwards characters/commands from upstream over a valid/ready
// handshake. Each byte is presented on LCD_RS/LCD_DATA, a write is requested
// from the enable-pulse stage with wr_go, and the bus is held until that
// stage reports completion through wr_done.
//
// Ports:
//   CLK        in   system clock, rising edge
//   flag_rst   in   asynchronous active-high reset
//   char_valid in   upstream has a byte to write
//   char_rs    in   register select of offered byte (0 = command, 1 = data)
//   char_data  in   offered byte [7:0]
//   char_ready out  byte accepted when high together with char_valid
//   wr_done    in   enable stage level: low while busy, high when done/idle
//   wr_go      out  write request level, held until wr_done is seen low
//   LCD_RS     out  register select to the LCD
//   LCD_RW     out  constant 0 (write only)
//   LCD_DATA   out  LCD data bus [7:0]
//   init_done  out  initialization finished, sticky until reset
module lcd_cmd_sequencer #(
  parameter int unsigned P_PWRUP_CYC = 750000
) (
  input  logic       CLK,
  input  logic       flag_rst,
  input  logic       char_valid,
  input  logic       char_rs,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       wr_done,
  output logic       wr_go,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       init_done
);

  localparam logic [22:0] PWRUP_MAX  = 23'(P_PWRUP_CYC);
  localparam logic [2:0]  LAST_INDEX = 3'd5;

  typedef enum logic [1:0] {
    S_PWRUP   = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_IDLE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [22:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        go_q, go_d;
  logic        ready_q, ready_d;
  logic        init_q, init_d;

  // Fixed initialization bytes, all sent as commands (RS=0).
  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      3'd5:             init_rom = 8'h06;
      default:          init_rom = 8'h00;
    endcase
  endfunction

  // Power-up may only end once the counter has expired AND the enable stage
  // reports idle; a slow-starting enable stage must not lose ROM[0].
  logic pwrup_exit;
  logic init_more;
  assign pwrup_exit = (cnt_q == PWRUP_MAX) && wr_done;
  assign init_more  = !init_q && (idx_q < LAST_INDEX);

  // State and register update.
  always_ff @(posedge CLK or posedge flag_rst) begin
    if (flag_rst) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      go_q    <= 1'b0;
      ready_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      go_q    <= go_d;
      ready_q <= ready_d;
      init_q  <= init_d;
    end
  end

  // Next state, power-up counter and init index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q != PWRUP_MAX) cnt_d = cnt_q + 23'd1;
        if (pwrup_exit) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!wr_done) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (wr_done) begin
          if (init_more) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (char_valid) state_d = S_ISSUE;
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // Registered outputs: bus is only reloaded on the edges that raise wr_go.
  always_comb begin
    rs_d    = rs_q;
    data_d  = data_q;
    go_d    = go_q;
    ready_d = ready_q;
    init_d  = init_q;
    case (state_q)
      S_PWRUP: begin
        if (pwrup_exit) begin
          rs_d   = 1'b0;
          data_d = init_rom(3'd0);
          go_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!wr_done) go_d = 1'b0;
      end
      S_WAIT_HI: begin
        if (wr_done) begin
          if (init_more) begin
            rs_d   = 1'b0;
            data_d = init_rom(idx_q + 3'd1);
            go_d   = 1'b1;
          end else begin
            // Covers both the last init byte and any user write.
            ready_d = 1'b1;
            init_d  = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (char_valid) begin
          rs_d    = char_rs;
          data_d  = char_data;
          ready_d = 1'b0;
          go_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign char_ready = ready_q;
  assign wr_go      = go_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_DATA   = data_q;
  assign init_done  = init_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer with a modelled enable stage.
module tb_lcd_cmd_sequencer;
  localparam int P = 10;

  logic       CLK = 1'b0;
  logic       flag_rst = 1'b1;
  logic       char_valid = 1'b0;
  logic       char_rs = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       wr_done = 1'b1;
  logic       char_ready, wr_go, LCD_RS, LCD_RW, init_done;
  logic [7:0] LCD_DATA;

  int vectors = 0;
  int miscompares = 0;

  // Enable-stage model control: 0 normal, 1 never acknowledges, 2 held low.
  int stage_mode = 0;
  int busy = 0;

  int cyc = 0;
  int first_go = -1;
  logic [8:0] log_q[$];
  logic [8:0] sent_q[$];
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Behavioural model, expressed as write transactions.
  logic       m_go = 1'b0, m_wait = 1'b0, m_ready = 1'b0, m_init = 1'b0, m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_pwr = 0;
  int         n_init = 0;

  lcd_cmd_sequencer #(.P_PWRUP_CYC(P)) dut (
    .CLK(CLK), .flag_rst(flag_rst), .char_valid(char_valid), .char_rs(char_rs),
    .char_data(char_data), .char_ready(char_ready), .wr_done(wr_done), .wr_go(wr_go),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA), .init_done(init_done)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Enable stage: drops 1 cycle after a request, rises 20 cycles later.
  initial forever begin
    @(posedge CLK or posedge flag_rst);
    if (stage_mode == 2) begin
      wr_done <= 1'b0; busy = 0;
    end else if (flag_rst) begin
      wr_done <= 1'b1; busy = 0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) wr_done <= 1'b1;
    end else if (stage_mode == 0 && wr_go && wr_done) begin
      wr_done <= 1'b0; busy = 20;
    end else begin
      wr_done <= 1'b1;
    end
  end

  task automatic m_issue(input logic rs, input logic [7:0] d);
    m_go = 1'b1; m_wait = 1'b1; m_rs = rs; m_data = d;
  endtask

  // Model step on each edge, from the inputs seen at that edge.
  initial forever begin
    @(posedge CLK or posedge flag_rst);
    if (flag_rst) begin
      m_go = 0; m_wait = 0; m_ready = 0; m_init = 0; m_rs = 0; m_data = 8'h00;
      m_pwr = 0; n_init = 0; cyc = 0;
    end else begin
      cyc++;
      if (m_go) begin
        if (!wr_done) m_go = 1'b0;           // request taken, now awaiting completion
      end else if (m_wait) begin
        if (wr_done) begin
          m_wait = 1'b0;
          if (!m_init) begin
            n_init++;
            if (n_init < 6) m_issue(1'b0, rom[n_init]);
            else begin m_init = 1'b1; m_ready = 1'b1; end
          end else begin
            m_ready = 1'b1;
          end
        end
      end else if (m_ready) begin
        if (char_valid) begin
          m_ready = 1'b0;
          m_issue(char_rs, char_data);
        end
      end else begin
        if (m_pwr == P && wr_done) m_issue(1'b0, rom[0]);
        if (m_pwr < P) m_pwr++;
      end
    end
  end

  // Per-cycle comparison, bus stability and write logging.
  logic       prev_go = 1'b0, prev_rs = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;
  initial forever begin
    @(negedge CLK);
    chk("wr_go", wr_go, m_go);
    chk("char_ready", char_ready, m_ready);
    chk("init_done", init_done, m_init);
    chk("lcd_rs", LCD_RS, m_rs);
    chk("lcd_data", LCD_DATA, m_data);
    chk("lcd_rw", LCD_RW, 0);
    if (!flag_rst && !prev_rst)
      chk("bus_stable", ((LCD_RS !== prev_rs) || (LCD_DATA !== prev_data)) && !(wr_go && !prev_go), 0);
    if (wr_go && !prev_go) begin
      log_q.push_back({LCD_RS, LCD_DATA});
      if (first_go < 0) first_go = cyc;
    end
    prev_go = wr_go; prev_rs = LCD_RS; prev_data = LCD_DATA; prev_rst = flag_rst;
  end

  // which: 0 = init_done high, 1 = char_ready high, 2 = wr_go low
  task automatic wait_for(input int which, input int limit, input string nm);
    bit hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge CLK); #1;
      case (which)
        0: hit = init_done;
        1: hit = char_ready;
        default: hit = !wr_go;
      endcase
    end
    if (!hit) chk(nm, 0, 1);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    bit done = 0;
    char_rs = rs; char_data = d; char_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK); #1;
      if (char_ready) begin
        @(posedge CLK); #2;
        char_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      chk("send_timeout", 0, 1);
      char_valid = 1'b0;
    end
    sent_q.push_back({rs, d});
  endtask

  task automatic do_reset(input int mode);
    @(posedge CLK); #2;
    stage_mode = mode;
    flag_rst = 1'b1;
    log_q.delete();
    first_go = -1;
    #1;
    chk("async_rst_go", wr_go, 0);
    chk("async_rst_ready", char_ready, 0);
    chk("async_rst_init", init_done, 0);
    chk("async_rst_data", LCD_DATA, 8'h00);
    repeat (2) @(posedge CLK);
    #2 flag_rst = 1'b0;
  endtask

  task automatic check_init_log(input string nm);
    chk({nm, "_count"}, log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk({nm, "_byte"}, log_q[i], {1'b0, rom[i]});
  endtask

  initial begin
    logic [7:0] d;
    logic       rs;
    // Byte offered from reset onward must wait for init.
    char_valid = 1'b1; char_rs = 1'b1; char_data = 8'h55;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_go", wr_go, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_init", init_done, 0);
    chk("rst_data", LCD_DATA, 8'h00);
    chk("rst_rs", LCD_RS, 0);
    @(posedge CLK); #2 flag_rst = 1'b0;

    wait_for(0, 400, "init_timeout");
    chk("first_go_min", first_go >= P, 1);
    chk("ready_with_init", char_ready, 1);
    check_init_log("init_seq");
    @(posedge CLK); #2 char_valid = 1'b0;   // handshake took place at that edge
    wait_for(1, 100, "held_byte_timeout");
    repeat (5) @(posedge CLK);
    chk("held_byte_count", log_q.size(), 7);
    if (log_q.size() >= 7) chk("held_byte", log_q[6], {1'b1, 8'h55});

    // Single data write.
    @(posedge CLK); #2;
    send(1'b1, 8'h41);
    @(negedge CLK); #1;
    chk("w41_rs", LCD_RS, 1);
    chk("w41_data", LCD_DATA, 8'h41);
    chk("w41_go", wr_go, 1);
    chk("w41_ready", char_ready, 0);
    wait_for(1, 100, "w41_timeout");
    chk("w41_hold", LCD_DATA, 8'h41);

    // Randomized writes, offered at random times (often while busy).
    @(posedge CLK); #2;
    log_q.delete(); sent_q.delete();
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 30)) @(posedge CLK);
      #2;
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      send(rs, d);
    end
    wait_for(1, 100, "rand_timeout");
    chk("rand_count", log_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < log_q.size(); i++)
      chk("rand_byte", log_q[i], sent_q[i]);

    // Enable stage never acknowledges.
    @(posedge CLK); #2 stage_mode = 1;
    send(1'b0, 8'h80);
    repeat (40) @(posedge CLK);
    @(negedge CLK); #1;
    chk("stuck_go", wr_go, 1);
    chk("stuck_ready", char_ready, 0);
    chk("stuck_data", LCD_DATA, 8'h80);

    // Reset mid-write, then a slow enable stage after power-up.
    do_reset(0);
    wait_for(0, 400, "reinit_timeout");
    @(posedge CLK); #2;
    send(1'b1, 8'h5A);
    wait_for(2, 100, "ack_timeout");
    repeat (3) @(posedge CLK);
    do_reset(2);
    for (int i = 0; i < 200 && cyc < 50; i++) @(negedge CLK);
    #1;
    chk("delayed_no_go", wr_go, 0);
    chk("delayed_no_write", log_q.size(), 0);
    @(posedge CLK); #2 stage_mode = 0;
    wait_for(0, 400, "delayed_init_timeout");
    chk("delayed_first_go", first_go > 50, 1);
    check_init_log("reinit_seq");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
